// File: rtl/msx_slot_config.sv
// msx_slot_config: cartridge-slot configuration engine.
//
// Decodes the per-slot type/mapper/SRAM menu selections for SLOTS cartridge slots into a
// candidate configuration, waits until that candidate has been stable for SETTLE_CYCLES
// cycles, then requests a reload from the cartridge loader. The committed configuration
// (all outputs) changes only on the edge where the loader acknowledges the request.
//
// Parameters
//   SLOTS          number of cartridge slots (1..4); slot 0 is the full-featured slot
//   SETTLE_CYCLES  consecutive stable cycles required before a change is requested (>= 1)
//
// Ports
//   clk            system clock
//   reset_n        asynchronous active-low reset
//   hold           system reset/boot in progress; blocks new requests
//   fdc_builtin    BIOS provides an internal FDC
//   typ_sel        per-slot type menu index, 3 bits per slot
//   mapper_sel     per-slot mapper menu index, 4 bits per slot (0 = auto, 1 = none)
//   sram_sel       per-slot SRAM menu index, 3 bits per slot (0 = auto, 1..6 = 1..32 kB, 7 = none)
//   reload_ack     loader accepts the pending configuration
//   reload_req     a new configuration is pending
//   slot_typ       committed type per slot
//   slot_mapper    committed mapper per slot (mapper_sel + 2, modulo 16)
//   slot_sram_kb   committed SRAM size in kB per slot
//   rom_load_hide  per slot: committed type is not ROM
//   sram_sel_hide  per slot: committed type is not ROM, or committed mapper_sel is auto
//   fdc_enabled    committed FDC enable
//   cfg_gen        commit counter, wraps 255 -> 0
//
// Build option
//   MSX_CFG_FDC_SLOT_EN  when defined, slot 0 type code 6 decodes to the cartridge FDC
//                        (unless the BIOS already provides one); when undefined, code 6
//                        decodes to EMPTY and fdc_enabled follows fdc_builtin only.

module msx_slot_config #(
  parameter int unsigned SLOTS         = 2,
  parameter int unsigned SETTLE_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 hold,
  input  logic                 fdc_builtin,
  input  logic [3*SLOTS-1:0]   typ_sel,
  input  logic [4*SLOTS-1:0]   mapper_sel,
  input  logic [3*SLOTS-1:0]   sram_sel,
  input  logic                 reload_ack,
  output logic                 reload_req,
  output logic [3*SLOTS-1:0]   slot_typ,
  output logic [4*SLOTS-1:0]   slot_mapper,
  output logic [8*SLOTS-1:0]   slot_sram_kb,
  output logic [SLOTS-1:0]     rom_load_hide,
  output logic [SLOTS-1:0]     sram_sel_hide,
  output logic                 fdc_enabled,
  output logic [7:0]           cfg_gen
);

  // Candidate/committed key layout:
  //   [KeyW-1]        valid (0 only before the first sample / first commit)
  //   [KeyW-2]        fdc enable
  //   slot i, 10 bits at [10*i +: 10] = {type[2:0], mapper_sel[3:0], sram_sel[2:0]}
  // SRAM size and the hide flags are pure functions of the key, so they are derived
  // from cand_q at commit time rather than stored in it.
  localparam int unsigned KeyW = 10 * SLOTS + 2;
  localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [2:0] TypRom   = 3'd0;
  localparam logic [2:0] TypFdc   = 3'd6;
  localparam logic [2:0] TypEmpty = 3'd7;

  // Committed key reset value differs from the candidate reset value ('0) and carries
  // valid=0, so no sampled candidate can ever match it: the first configuration after
  // reset is always requested.
  localparam logic [KeyW-1:0] CmtKeyRst = {1'b0, {(KeyW - 1){1'b1}}};

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StReq
  } state_e;

  state_e              state_q;
  logic [CntW-1:0]     cnt_q;
  logic                req_q;
  logic [7:0]          gen_q;
  logic [KeyW-1:0]     cand_d;
  logic [KeyW-1:0]     cand_q;
  logic [KeyW-1:0]     cmt_key_q;
  logic                cand_changed;

  logic [2:0]          typ_dec [SLOTS];

  logic [3*SLOTS-1:0]  typ_q;
  logic [4*SLOTS-1:0]  map_q;
  logic [8*SLOTS-1:0]  kb_q;
  logic [SLOTS-1:0]    rom_hide_q;
  logic [SLOTS-1:0]    sram_hide_q;
  logic                fdc_q;

  logic [3*SLOTS-1:0]  new_typ;
  logic [4*SLOTS-1:0]  new_map;
  logic [8*SLOTS-1:0]  new_kb;
  logic [SLOTS-1:0]    new_rom_hide;
  logic [SLOTS-1:0]    new_sram_hide;

  // ---------------------------------------------------------------------------------------
  // Type decode
  // ---------------------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < SLOTS; i++) begin
      typ_dec[i] = TypEmpty;
      if (i == 0) begin
        if (typ_sel[2:0] <= 3'd5) begin
          typ_dec[i] = typ_sel[2:0];
`ifdef MSX_CFG_FDC_SLOT_EN
        end else if (typ_sel[2:0] == TypFdc && !fdc_builtin) begin
          // A cartridge FDC is only useful when the BIOS has none of its own.
          typ_dec[i] = TypFdc;
`endif
        end
      end else if (typ_sel[3*i +: 3] <= 3'd3) begin
        typ_dec[i] = typ_sel[3*i +: 3];
      end
    end
  end

  // ---------------------------------------------------------------------------------------
  // Candidate key
  // ---------------------------------------------------------------------------------------
  always_comb begin
    cand_d = '0;
    cand_d[KeyW-1] = 1'b1;
`ifdef MSX_CFG_FDC_SLOT_EN
    cand_d[KeyW-2] = fdc_builtin | (typ_dec[0] == TypFdc);
`else
    cand_d[KeyW-2] = fdc_builtin;
`endif
    for (int i = 0; i < SLOTS; i++) begin
      cand_d[10*i+7 +: 3] = typ_dec[i];
      cand_d[10*i+3 +: 4] = mapper_sel[4*i +: 4];
      cand_d[10*i   +: 3] = sram_sel[3*i +: 3];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cand_q <= '0;
    end else begin
      cand_q <= cand_d;
    end
  end

  // cand_q is about to take a different value on this edge.
  assign cand_changed = (cand_d != cand_q);

  // ---------------------------------------------------------------------------------------
  // Output values that a commit on this edge would publish
  // ---------------------------------------------------------------------------------------
  always_comb begin
    new_typ       = '0;
    new_map       = '0;
    new_kb        = '0;
    new_rom_hide  = '0;
    new_sram_hide = '0;
    for (int i = 0; i < SLOTS; i++) begin
      new_typ[3*i +: 3]  = cand_q[10*i+7 +: 3];
      new_map[4*i +: 4]  = cand_q[10*i+3 +: 4] + 4'd2;
      new_rom_hide[i]    = (cand_q[10*i+7 +: 3] != TypRom);
      new_sram_hide[i]   = new_rom_hide[i] | (cand_q[10*i+3 +: 4] == 4'd0);
      // SRAM only for a ROM slot with an explicit mapper (> none) and an explicit size.
      if (!new_rom_hide[i] && (cand_q[10*i+3 +: 4] > 4'd1) &&
          (cand_q[10*i +: 3] != 3'd0) && (cand_q[10*i +: 3] != 3'd7)) begin
        new_kb[8*i +: 8] = 8'd1 << (cand_q[10*i +: 3] - 3'd1);
      end
    end
  end

  // ---------------------------------------------------------------------------------------
  // Settle / request / commit FSM
  // ---------------------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StSettle;
      cnt_q       <= '0;
      req_q       <= 1'b0;
      gen_q       <= 8'd0;
      cmt_key_q   <= CmtKeyRst;
      typ_q       <= {SLOTS{TypEmpty}};
      map_q       <= '0;
      kb_q        <= '0;
      rom_hide_q  <= '1;
      sram_hide_q <= '1;
      fdc_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Also look at cand_d so a change landing on this edge starts its settle window
          // right away; cand_q covers a difference that accumulated while hold was high.
          if (!hold && ((cand_q != cmt_key_q) || (cand_d != cmt_key_q))) begin
            state_q <= StSettle;
            cnt_q   <= '0;
          end
        end
        StSettle: begin
          if (cand_changed || hold) begin
            cnt_q <= '0;
          end else if (cand_q == cmt_key_q) begin
            state_q <= StIdle;
          end else if (cnt_q == CntW'(SETTLE_CYCLES - 1)) begin
            state_q <= StReq;
            req_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StReq: begin
          // Hold is ignored here: the request is never withdrawn once raised.
          if (reload_ack) begin
            state_q     <= StSettle;
            cnt_q       <= '0;
            req_q       <= 1'b0;
            gen_q       <= gen_q + 8'd1;
            cmt_key_q   <= cand_q;
            typ_q       <= new_typ;
            map_q       <= new_map;
            kb_q        <= new_kb;
            rom_hide_q  <= new_rom_hide;
            sram_hide_q <= new_sram_hide;
            fdc_q       <= cand_q[KeyW-2];
          end
        end
        default: begin
          state_q <= StSettle;
          cnt_q   <= '0;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign reload_req    = req_q;
  assign slot_typ      = typ_q;
  assign slot_mapper   = map_q;
  assign slot_sram_kb  = kb_q;
  assign rom_load_hide = rom_hide_q;
  assign sram_sel_hide = sram_hide_q;
  assign fdc_enabled   = fdc_q;
  assign cfg_gen       = gen_q;

endmodule

// File: doc/msx_slot_config.md
# msx_slot_config

Parametrised cartridge-slot configuration engine for the MSX core; successor to the two-slot combinational config decoder. Decodes per-slot type/mapper/SRAM menu selections for `SLOTS` cartridge slots, debounces them, and publishes a committed configuration. Configuration changes reach the slot logic only through a settle counter and a `reload_req`/`reload_ack` handshake with the cartridge loader. Sits between the HPS status decode and the cartridge/mapper subsystem.

## Interface
- `SLOTS`, 2: number of cartridge slots, 1..4; slot 0 is the full-featured slot.
- `SETTLE_CYCLES`, 1024: consecutive stable cycles required before a change is requested; ≥1.
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `hold` in 1: system reset/boot in progress; blocks new requests.
- `fdc_builtin` in 1: BIOS provides an internal FDC.
- `typ_sel` in 3×SLOTS: per-slot type menu index; slot i at [3i+2:3i].
- `mapper_sel` in 4×SLOTS: per-slot mapper menu index; 0 = auto, 1 = none.
- `sram_sel` in 3×SLOTS: per-slot SRAM menu index; 0 = auto, 1..6 = 1..32 kB, 7 = none.
- `reload_ack` in 1: loader accepts the pending configuration.
- `reload_req` out 1: a new configuration is pending.
- `slot_typ` out 3×SLOTS: committed type per slot.
- `slot_mapper` out 4×SLOTS: committed mapper, `mapper_sel + 2`, modulo 16.
- `slot_sram_kb` out 8×SLOTS: committed SRAM size in kB.
- `rom_load_hide` out SLOTS: 1 when the committed type ≠ ROM.
- `sram_sel_hide` out SLOTS: 1 when the committed type ≠ ROM, or when the committed `mapper_sel` = 0.
- `fdc_enabled` out 1: committed FDC enable.
- `cfg_gen` out 8: commit counter, incremented on every commit; wraps 255→0.

## Operation
- **Type codes**
  - ROM=0, SCC=1, SCC+=2, FM-PAC=3, MFRSD=4, GM2=5, FDC=6, EMPTY=7.
- **Type decode, slot 0**
  - Codes 0..5 pass through.
  - Code 6 → FDC if `fdc_builtin`=0, else EMPTY.
  - Code 7 → EMPTY.
- **Type decode, slots ≥1**
  - Codes 0..3 pass through.
  - All other codes → EMPTY.
- **SRAM decode**
  - Size is `1 << (sram_sel-1)` kB only when decoded type = ROM, `mapper_sel` > 1 and `sram_sel` ∈ 1..6.
  - Otherwise 0.
- **Candidate**
  - All decoded fields plus raw `mapper_sel` and `sram_sel` are registered every cycle into `cand_q`.
  - `fdc_enabled` candidate = `fdc_builtin` | (slot 0 type = FDC).
- **FSM**
  - IDLE
    - `cand_q` ≠ committed and `hold`=0 → SETTLE, counter cleared.
  - SETTLE
    - `cand_q` changed since the previous cycle, or `hold`=1 → counter cleared.
    - `cand_q` = committed → IDLE.
    - Counter reaches `SETTLE_CYCLES`-1 with `cand_q` unchanged → REQ.
  - REQ
    - `reload_req`=1 and held until `reload_ack`; the request is never withdrawn.
    - On ack, the current `cand_q` is copied to committed, `cfg_gen`++, then → SETTLE with counter cleared.
    - SETTLE returns to IDLE if the configuration is unchanged.
- **Simultaneous events**
  - `reload_ack` outside REQ is ignored.
  - A candidate change during REQ is absorbed by the commit if it is present at the ack edge; otherwise a new cycle follows.
  - `hold` during REQ has no effect.

## Timing
- **Reset values**
  - FSM = SETTLE, counter = 0, `reload_req`=0, `cfg_gen`=0.
  - All `slot_typ`=7, `slot_mapper`=0, `slot_sram_kb`=0.
  - All `rom_load_hide`=1, all `sram_sel_hide`=1, `fdc_enabled`=0.
- Reset entering SETTLE means the initial configuration is always requested once after reset.
- **Latency**
  - An input change at edge t appears in `cand_q` at t+1.
  - `reload_req` rises at t+1+`SETTLE_CYCLES` if the input stays stable and `hold`=0.
- **Commit**
  - `reload_ack` sampled high at edge k → committed outputs update and `reload_req` falls at edge k.
  - Ack in the same cycle `reload_req` first rises is valid.
- All outputs are registered; none depend combinationally on inputs.
- Asserting reset mid-operation aborts any SETTLE/REQ immediately; outputs return to reset values.

## Configuration
- `MSX_CFG_FDC_SLOT_EN` defined: slot 0 code 6 decodes to FDC as above.
- `MSX_CFG_FDC_SLOT_EN` undefined: slot 0 code 6 → EMPTY, and `fdc_enabled` = committed `fdc_builtin` only.

## Test plan
- **Post-reset request:** release reset with `SETTLE_CYCLES`=4, slot 0 `typ_sel`=0, `mapper_sel`=3, `sram_sel`=4 → `reload_req` high 5 cycles after release. Ack → `slot_typ[0]`=0, `slot_mapper[0]`=5, `slot_sram_kb[0]`=8, `cfg_gen`=1, back to IDLE.
- **Debounce:** toggle `typ_sel` every 2 cycles with `SETTLE_CYCLES`=4 → no `reload_req`. Stop toggling → `reload_req` exactly 5 cycles after the last change.
- **Slot restriction:** slot 1 `typ_sel`=4 → `slot_typ[1]`=7 and `rom_load_hide[1]`=1.
- **FDC arbitration:**
  - Slot 0 `typ_sel`=6 with `fdc_builtin`=1 → type 7, `fdc_enabled`=1.
  - With `fdc_builtin`=0 and macro defined → type 6, `fdc_enabled`=1.
  - With the macro undefined → type 7, `fdc_enabled`=0.
- **Change during REQ:** change `mapper_sel` while `reload_req`=1, then ack → the new value is committed, `cfg_gen` increments once, IDLE follows with no second request.
- **Hold and wrap:**
  - `hold`=1 keeps the FSM out of REQ indefinitely.
  - 256 commits → `cfg_gen` wraps to 0.
